// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: sequential RV32M multiply/divide unit, one radix-2 step per cycle.
// Define EX_MULDIV_DIV_EN to build in the restoring divider; without it, ops 1xx finish at once with 0.
module ex_muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard_flush,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  result_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;

  state_t      state_reg;
  logic [2:0]  op_reg;
  logic [4:0]  rd_reg;
  logic [5:0]  count_reg;
  logic [31:0] opb_reg;
  logic [63:0] acc_reg;
  logic        res_neg_reg;
  logic        done_reg;
  logic [31:0] result_reg;
  logic [4:0]  result_rd_reg;
`ifdef EX_MULDIV_DIV_EN
  logic        rem_neg_reg;
`endif

  logic        a_signed;
  logic        b_signed;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        accept;
  logic        special;
  logic [31:0] special_result;

  // Work on magnitudes; the sign is reapplied once the unsigned iteration finishes.
  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    neg_a    = a_signed & rs1[31];
    neg_b    = b_signed & rs2[31];
    mag_a    = neg_a ? (~rs1 + 32'd1) : rs1;
    mag_b    = neg_b ? (~rs2 + 32'd1) : rs2;
  end

  assign accept = (state_reg == IDLE) && start && !hazard_flush;
  assign busy   = (state_reg == ITER) || accept;

  always_comb begin
    special        = 1'b0;
    special_result = 32'd0;
`ifdef EX_MULDIV_DIV_EN
    if (op[2]) begin
      if (rs2 == 32'd0) begin
        special        = 1'b1;
        special_result = op[1] ? rs1 : 32'hFFFF_FFFF;
      end else if (!op[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF)) begin
        special        = 1'b1;
        special_result = op[1] ? 32'd0 : 32'h8000_0000;
      end
    end
`else
    if (op[2]) begin
      special        = 1'b1;
      special_result = 32'd0;
    end
`endif
  end

  logic [32:0] mul_sum;
  logic [63:0] acc_next;
  logic [63:0] prod_fix;
  logic [31:0] final_result;
`ifdef EX_MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
`endif

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opb_reg} : 33'd0);
    acc_next = {mul_sum, acc_reg[31:1]};
`ifdef EX_MULDIV_DIV_EN
    div_shift = acc_reg[63:31];
    div_diff  = div_shift - {1'b0, opb_reg};
    if (op_reg[2]) begin
      if (div_shift >= {1'b0, opb_reg})
        acc_next = {div_diff[31:0], acc_reg[30:0], 1'b1};
      else
        acc_next = {div_shift[31:0], acc_reg[30:0], 1'b0};
    end
`endif
  end

  always_comb begin
    prod_fix     = res_neg_reg ? (~acc_next + 64'd1) : acc_next;
    final_result = (op_reg[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef EX_MULDIV_DIV_EN
    quo_fix = res_neg_reg ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    rem_fix = rem_neg_reg ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    if (op_reg[2])
      final_result = op_reg[1] ? rem_fix : quo_fix;
`else
    if (op_reg[2])
      final_result = 32'd0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= 3'd0;
      rd_reg        <= 5'd0;
      count_reg     <= 6'd0;
      opb_reg       <= 32'd0;
      acc_reg       <= 64'd0;
      res_neg_reg   <= 1'b0;
      done_reg      <= 1'b0;
      result_reg    <= 32'd0;
      result_rd_reg <= 5'd0;
`ifdef EX_MULDIV_DIV_EN
      rem_neg_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (hazard_flush) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              op_reg      <= op;
              rd_reg      <= rd;
              count_reg   <= 6'd0;
              acc_reg     <= {32'd0, mag_a};
              opb_reg     <= mag_b;
              res_neg_reg <= neg_a ^ neg_b;
`ifdef EX_MULDIV_DIV_EN
              rem_neg_reg <= neg_a;
`endif
              if (special) begin
                state_reg     <= DONE;
                done_reg      <= 1'b1;
                result_reg    <= special_result;
                result_rd_reg <= rd;
              end else begin
                state_reg <= ITER;
              end
            end
          end
          ITER: begin
            acc_reg   <= acc_next;
            count_reg <= count_reg + 6'd1;
            if (count_reg == 6'd31) begin
              state_reg     <= DONE;
              done_reg      <= 1'b1;
              result_reg    <= final_result;
              result_rd_reg <= rd_reg;
            end
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign done      = done_reg;
  assign result    = result_reg;
  assign result_rd = result_rd_reg;

endmodule

// File: doc/ex_muldiv_seq.md
EX_MULDIV_SEQ -- requirements
Module: ex_muldiv_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 hazard_flush  input  1  abort the in-flight operation.
REQ-005 start  input  1  request a multiply or divide op (ID/EX enabled and M-extension op).
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 rs1  input  32  operand A (already forwarded).
REQ-008 rs2  input  32  operand B (already forwarded).
REQ-009 rd  input  5  destination register tag.
REQ-010 busy  output  1  stall request to the hazard unit.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result  output  32  op result, valid while done=1.
REQ-013 result_rd  output  5  destination tag, valid while done=1.

Function
REQ-014 FSM states SHALL be IDLE, ITER, DONE.
REQ-015 start SHALL be accepted only in IDLE with hazard_flush=0.
- On acceptance: latch op and rd; latch operand magnitudes plus result-sign flags per op signedness; clear the 6-bit iteration counter.
- Then go to ITER, or straight to DONE for a REQ-019 special case.
REQ-016 start SHALL be ignored in ITER and DONE.
REQ-017 ITER SHALL run one radix-2 step per cycle for exactly 32 cycles, then go to DONE.
- Multiply: shift-add on a 64-bit product.
- Divide: restoring, 32-bit quotient plus remainder.
REQ-018 DONE SHALL last one cycle with done=1, result and result_rd valid, and SHALL then return to IDLE.
- Latency: done is high in the 33rd cycle after the accepting edge.
REQ-019 Special divide cases SHALL skip ITER and reach DONE on the accepting edge, so done is high in the next cycle.
- Divisor 0: quotient 0xFFFFFFFF; remainder = rs1.
- Signed DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000; remainder 0.
REQ-020 Result selection SHALL be as follows.
- MUL: low 32 product bits.
- MULH / MULHSU / MULHU: high 32 bits of the two's-complement 64-bit product.
- DIV / DIVU: quotient, rounded toward zero.
- REM / REMU: remainder, taking the sign of the dividend.
REQ-021 busy SHALL equal (state==ITER) OR (state==IDLE AND start AND NOT hazard_flush), combinationally; busy SHALL be 0 in DONE so that the EX/MEM register captures the result.
REQ-022 hazard_flush SHALL force IDLE on the next edge from any state, suppressing done; result and result_rd SHALL hold their values.
- If hazard_flush and start are both high, flush wins and the op is not accepted.
REQ-023 done SHALL never be high for two consecutive cycles.
REQ-024 result and result_rd SHALL hold their last values outside DONE.

Reset
REQ-025 While reset=1, the block SHALL set: state IDLE, counter 0, done 0, result 0x00000000, result_rd 0, all internal operand/accumulator registers 0.
REQ-026 Reset asserted mid-operation SHALL abandon it; the first start after release SHALL complete with normal latency.

Configuration
REQ-027 Macro EX_MULDIV_DIV_EN SHALL control the divide datapath.
- Defined: the divide datapath is compiled in and ops 100-111 behave per REQ-017..REQ-020.
- Undefined: the divider is removed; ops 100-111 SHALL go IDLE->DONE on the accepting edge with result 0x00000000; multiply ops are unchanged.

Verification
REQ-028 MUL: rs1=7, rs2=0xFFFFFFFD (-3), start 1 cycle -> busy high 33 cycles including the accept cycle; done in cycle 33 after accept; result 0xFFFFFFEB; result_rd=rd.
REQ-029 MULHU: rs1=rs2=0xFFFFFFFF -> result 0xFFFFFFFE. MULH with the same operands -> 0x00000000.
REQ-030 DIV: rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
REQ-031 DIVU: rs1=0x1234, rs2=0 -> done in the cycle after accept; result 0xFFFFFFFF. REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-032 Abort and recovery:
- Start MUL, assert hazard_flush in ITER cycle 10 -> no done pulse; IDLE next cycle; a new MUL of 3*5 returns 15 with full latency.
- Reset pulsed in ITER gives the same recovery.
REQ-033 Without EX_MULDIV_DIV_EN: DIV 10/2 -> done in the cycle after accept; result 0x00000000; MUL 6*7 still returns 42.
